// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared state encoding, default widths and response type for the APB master bridge
package apb_master_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] rdata;
        logic                  err;
    } rsp_t;

endpackage

// File: rtl/apb_master_bridge_if.sv
// rtl/apb_master_bridge_if.sv - command/response and APB bus bundle; master = bridge side, slave = environment side
interface apb_master_bridge_if
    import apb_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  pready, prdata, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output paddr, pwdata, psel, penable, pwrite
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output pready, prdata, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  paddr, pwdata, psel, penable, pwrite
    );

endinterface

// File: rtl/apb_timeout_counter.sv
// rtl/apb_timeout_counter.sv - counts ACCESS cycles and flags the last allowed one
module apb_timeout_counter #(
    parameter int TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // expired is high during the TIMEOUT_CYC-th counted cycle, so the caller can still let pready win
    assign expired = count_en && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - valid/ready command to APB SETUP/ACCESS initiator, one transfer in flight
// Optional ACCESS-phase timeout abort: APB_MASTER_TIMEOUT_EN
module apb_master_bridge
    import apb_master_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
`ifdef APB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 256
`endif
) (
    input  logic                pclk,
    input  logic                presetn,
    apb_master_bridge_if.master bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    logic              rsp_valid_q, rsp_valid_d;
    rsp_t              rsp_q, rsp_d;
    logic              cmd_ready;
    logic              abort;

`ifdef APB_MASTER_TIMEOUT_EN
    logic expired;

    apb_timeout_counter #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk      (pclk),
        .resetn   (presetn),
        .clear    (state_q == SETUP),
        .count_en (state_q == ACCESS),
        .expired  (expired)
    );

    assign abort = expired && !bus.pready;
`else
    assign abort = 1'b0;
`endif

    // gated by presetn so no command can be taken while reset is held
    assign cmd_ready = presetn && (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_valid_d = 1'b0;
        rsp_d       = rsp_q;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready) begin
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    pwrite_d = bus.cmd_write;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    rsp_valid_d = 1'b1;
                    rsp_d.err   = bus.pslverr;
                    rsp_d.rdata = (!pwrite_q && !bus.pslverr) ? DEF_DATA_W'(bus.prdata) : '0;
                    state_d     = IDLE;
                end else if (abort) begin
                    rsp_valid_d = 1'b1;
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_q       <= rsp_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.psel      = (state_q != IDLE);
    assign bus.penable   = (state_q == ACCESS);
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = DATA_W'(rsp_q.rdata);
    assign bus.rsp_err   = rsp_q.err;

endmodule
